// File: rtl/pcileech_fifo_tx_arb.sv
// Round-robin packet arbiter feeding the shared FIFO-to-COM 64-bit TX path.
// Optional: define PCILEECH_TXARB_PRIO0_EN to give source 0 absolute priority.
module pcileech_fifo_tx_arb #(
  parameter int NUM_SRC   = 3,
  parameter int DATA_W    = 64,
  parameter int MAX_BEATS = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC-1:0]        src_last,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [2:0]                out_src,
  input  logic                      out_ready,
  output logic                      err_overrun,
  output logic                      busy
);

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  state_t              r_state;
  logic [2:0]          r_grant;
  logic [2:0]          r_last_grant;
  logic [7:0]          r_beat_cnt;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_valid;
  logic                r_out_last;
  logic [2:0]          r_out_src;
  logic                r_err;

  logic                w_burst;
  logic                w_pipe_ok;
  logic                w_sel_valid;
  logic                w_sel_last;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_src_fire;
  logic                w_cap;
  logic                w_force;
  logic [2:0]          w_pick;

  // First requester after the last granted one, wrapping modulo NUM_SRC.
  function automatic logic [2:0] rr_pick(
    input logic [NUM_SRC-1:0] req,
    input logic [2:0]         last
  );
    logic [2:0] pick;
    logic       found;
    logic [3:0] idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = {1'b0, last} + 4'(k);
      if (idx >= 4'(NUM_SRC))
        idx = idx - 4'(NUM_SRC);
      for (int j = 0; j < NUM_SRC; j++) begin
`ifdef PCILEECH_TXARB_PRIO0_EN
        if (!found && j != 0 && idx == 4'(j) && req[j]) begin
`else
        if (!found && idx == 4'(j) && req[j]) begin
`endif
          pick  = 3'(j);
          found = 1'b1;
        end
      end
    end
`ifdef PCILEECH_TXARB_PRIO0_EN
    if (req[0])
      pick = '0;
`endif
    return pick;
  endfunction

  assign w_burst   = (r_state == S_BURST);
  assign w_pipe_ok = ~r_out_valid | out_ready;
  assign w_pick    = rr_pick(src_valid, r_last_grant);

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    src_ready   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_grant == 3'(i)) begin
        w_sel_valid  = src_valid[i];
        w_sel_last   = src_last[i];
        w_sel_data   = src_data[i*DATA_W +: DATA_W];
        src_ready[i] = w_burst & w_pipe_ok;
      end
    end
  end

  assign w_src_fire = w_burst & w_sel_valid & w_pipe_ok;
  assign w_cap      = ((r_beat_cnt + 8'd1) == 8'(MAX_BEATS));
  assign w_force    = w_src_fire & ~w_sel_last & w_cap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= 3'(NUM_SRC - 1);
      r_beat_cnt   <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_src    <= '0;
      r_err        <= 1'b0;
    end else begin
      r_err <= w_force;
      if (w_src_fire) begin
        r_out_data  <= w_sel_data;
        r_out_last  <= w_sel_last | w_cap;
        r_out_src   <= r_grant;
        r_out_valid <= 1'b1;
      end else if (r_out_valid & out_ready) begin
        r_out_valid <= 1'b0;
      end
      unique case (r_state)
        S_IDLE: begin
          if (|src_valid) begin
            r_grant    <= w_pick;
            r_beat_cnt <= '0;
            r_state    <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_src_fire) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
            // Forced release: rest of the packet competes again.
            if (w_sel_last | w_cap) begin
              r_last_grant <= r_grant;
              r_state      <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;
  assign out_src     = r_out_src;
  assign err_overrun = r_err;
  assign busy        = w_burst | r_out_valid;

endmodule

// File: tb/tb_pcileech_fifo_tx_arb.sv
// Directed bench for pcileech_fifo_tx_arb (NUM_SRC=3, MAX_BEATS=4).
// Per-cycle output log is checked against hand-derived cycle positions.
module tb_pcileech_fifo_tx_arb;

  localparam int NS = 3;
  localparam int DW = 64;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NS*DW-1:0] src_data;
  logic [NS-1:0]   src_valid;
  logic [NS-1:0]   src_last;
  logic [NS-1:0]   src_ready;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_last;
  logic [2:0]      out_src;
  logic            out_ready;
  logic            err_overrun;
  logic            busy;

  always #5 clk = ~clk;

  pcileech_fifo_tx_arb #(
    .NUM_SRC  (NS),
    .DATA_W   (DW),
    .MAX_BEATS(MB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_data   (src_data),
    .src_valid  (src_valid),
    .src_last   (src_last),
    .src_ready  (src_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_src    (out_src),
    .out_ready  (out_ready),
    .err_overrun(err_overrun),
    .busy       (busy)
  );

  logic [64:0] sb [NS][16];
  int          slen [NS];
  int          sptr [NS];
  logic [NS-1:0] fire;
  int          cyc;
  int          stall_lo;
  int          stall_hi;

  logic        lg_ov   [64];
  logic        lg_last [64];
  logic        lg_busy [64];
  logic        lg_err  [64];
  logic [63:0] lg_data [64];
  logic [2:0]  lg_src  [64];
  logic [NS-1:0] lg_rdy [64];

  logic [63:0] ot_data [$];
  logic [2:0]  ot_src  [$];
  logic        ot_last [$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    for (int i = 0; i < NS; i++) begin
      if (sptr[i] < slen[i]) begin
        src_valid[i]          = 1'b1;
        src_data[i*DW +: DW]  = sb[i][sptr[i]][63:0];
        src_last[i]           = sb[i][sptr[i]][64];
      end else begin
        src_valid[i]          = 1'b0;
        src_data[i*DW +: DW]  = '0;
        src_last[i]           = 1'b0;
      end
    end
    out_ready = !(cyc >= stall_lo && cyc < stall_hi);
    @(negedge clk);
    fire = src_valid & src_ready;
    if (cyc < 64) begin
      lg_ov[cyc]   = out_valid;
      lg_last[cyc] = out_last;
      lg_busy[cyc] = busy;
      lg_err[cyc]  = err_overrun;
      lg_data[cyc] = out_data;
      lg_src[cyc]  = out_src;
      lg_rdy[cyc]  = src_ready;
    end
    if (out_valid && out_ready) begin
      ot_data.push_back(out_data);
      ot_src.push_back(out_src);
      ot_last.push_back(out_last);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++)
      if (fire[i]) sptr[i]++;
    cyc++;
  endtask

  task automatic clear_test();
    for (int i = 0; i < NS; i++) begin
      slen[i] = 0;
      sptr[i] = 0;
    end
    cyc      = 0;
    stall_lo = 0;
    stall_hi = 0;
    ot_data.delete();
    ot_src.delete();
    ot_last.delete();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    src_valid = '0;
    src_last  = '0;
    src_data  = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_test();
  endtask

  task automatic load(input int s, input int n, input int pkt,
                      input logic [63:0] base);
    for (int b = 0; b < n; b++)
      sb[s][b] = {((b % pkt) == pkt - 1), base + 64'(b)};
    slen[s] = n;
    sptr[s] = 0;
  endtask

  initial begin
    int errs;
    do_reset();

    // reset state
    check("rst_ov", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
    check("rst_src", out_src, 0);
    check("rst_rdy", src_ready, 0);
    check("rst_err", err_overrun, 0);
    check("rst_busy", busy, 0);

    // single 4-beat packet from source 1
    load(1, 4, 4, 64'hA0);
    repeat (8) tick();
    check("t1_ov_c1", lg_ov[1], 0);
    check("t1_rdy_c1", lg_rdy[1], 3'b010);
    for (int b = 0; b < 4; b++) begin
      check("t1_ov", lg_ov[2+b], 1);
      check("t1_data", lg_data[2+b], 64'hA0 + 64'(b));
      check("t1_src", lg_src[2+b], 1);
      check("t1_last", lg_last[2+b], (b == 3));
    end
    check("t1_busy_c5", lg_busy[5], 1);
    check("t1_busy_c6", lg_busy[6], 0);
    check("t1_ov_c6", lg_ov[6], 0);

    // three sources, two 2-beat packets each
    do_reset();
    for (int s = 0; s < NS; s++)
      load(s, 4, 2, 64'h100 * 64'(s + 1));
    repeat (22) tick();
    for (int k = 0; k < 6; k++) begin
      for (int b = 0; b < 2; b++) begin
        check("t2_ov", lg_ov[2+3*k+b], 1);
        check("t2_src", lg_src[2+3*k+b], 3'(k % 3));
        check("t2_data", lg_data[2+3*k+b],
              64'h100 * 64'(k % 3 + 1) + 64'(2 * (k / 3) + b));
        check("t2_last", lg_last[2+3*k+b], (b == 1));
      end
      if (k < 5) check("t2_gap", lg_ov[4+3*k], 0);
    end
    check("t2_count", ot_data.size(), 12);

    // forced release at MAX_BEATS
    do_reset();
    load(2, 6, 6, 64'hC0);
    repeat (12) tick();
    for (int b = 0; b < 6; b++) begin
      int c;
      c = (b < 4) ? 2 + b : 3 + b;
      check("t3_ov", lg_ov[c], 1);
      check("t3_data", lg_data[c], 64'hC0 + 64'(b));
      check("t3_src", lg_src[c], 2);
      check("t3_last", lg_last[c], (b == 3 || b == 5));
    end
    check("t3_gap", lg_ov[6], 0);
    check("t3_rdy_arb", lg_rdy[5], 0);
    check("t3_err_c5", lg_err[5], 1);
    errs = 0;
    for (int c = 0; c < 12; c++)
      if (lg_err[c]) errs++;
    check("t3_err_cnt", errs, 1);

    // downstream stall of 5 cycles
    do_reset();
    load(1, 4, 4, 64'hD0);
    stall_lo = 3;
    stall_hi = 8;
    repeat (12) tick();
    for (int c = 3; c < 8; c++) begin
      check("t4_hold_ov", lg_ov[c], 1);
      check("t4_hold_data", lg_data[c], 64'hD1);
      check("t4_hold_rdy", lg_rdy[c], 0);
    end
    check("t4_count", ot_data.size(), 4);
    for (int b = 0; b < 4; b++)
      check("t4_seq", ot_data[b], 64'hD0 + 64'(b));
    check("t4_c9", lg_data[9], 64'hD2);
    check("t4_c10_last", lg_last[10], 1);

    // asynchronous reset mid-packet
    do_reset();
    load(0, 4, 4, 64'hE0);
    repeat (4) tick();
    check("t5_pre_data", out_data, 64'hE2);
    rst_n = 1'b0;
    #1;
    check("t5_ov", out_valid, 0);
    check("t5_last", out_last, 0);
    check("t5_data", out_data, 0);
    check("t5_src", out_src, 0);
    check("t5_rdy", src_ready, 0);
    check("t5_busy", busy, 0);
    check("t5_err", err_overrun, 0);
    clear_test();
    src_valid = '0;
    src_last  = '0;
    #2;
    rst_n = 1'b1;
    repeat (5) tick();
    for (int c = 0; c < 5; c++)
      check("t5_idle_ov", lg_ov[c], 0);

    // sources 0 and 2 with back-to-back 1-beat packets
    do_reset();
    load(0, 4, 1, 64'h10);
    load(2, 4, 1, 64'h30);
    repeat (16) tick();
    for (int k = 0; k < 4; k++) begin
`ifdef PCILEECH_TXARB_PRIO0_EN
      check("t6_src", ot_src[k], 0);
      check("t6_data", ot_data[k], 64'h10 + 64'(k));
`else
      check("t6_src", ot_src[k], (k % 2 == 0) ? 0 : 2);
      check("t6_data", ot_data[k],
            ((k % 2 == 0) ? 64'h10 : 64'h30) + 64'(k / 2));
`endif
      check("t6_last", ot_last[k], 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
